// File: rtl/bcd_digit_entry.sv
// BCD keypad operand entry: shifts digits into a 4-digit register and offers it downstream.
// Optional feature: define BCD_ENTRY_SIGN_EN to add the sign_neg output toggled by key 0xD.
module bcd_digit_entry #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [15:0] operand_bcd,
  output logic [2:0]  digit_count,
  output logic        overflow,
`ifdef BCD_ENTRY_SIGN_EN
  output logic        sign_neg,
`endif
  output logic        op_valid,
  input  logic        op_ready
);

  localparam logic [2:0] FULL = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        key_acc;
  logic        is_digit;
  logic        is_clr;
  logic        is_bs;
  logic        is_ent;
`ifdef BCD_ENTRY_SIGN_EN
  logic        is_sign;
  logic        sgn_d;
`endif
  logic        lead_zero;
  logic        full;
  logic        hs;

  logic [15:0] opd_d;
  logic [2:0]  cnt_d;
  logic        ovf_d;
  logic        vld_d;
  logic        rdy_d;

  assign key_acc   = key_valid & key_ready;
  assign is_digit  = key_code <= 4'h9;
  assign is_clr    = key_code == 4'hA;
  assign is_bs     = key_code == 4'hB;
  assign is_ent    = key_code == 4'hC;
`ifdef BCD_ENTRY_SIGN_EN
  assign is_sign   = key_code == 4'hD;
`endif
  assign lead_zero = is_digit
                   & (key_code == 4'h0)
                   & (digit_count == 3'd0);
  assign full      = digit_count == FULL;
  assign hs        = op_valid & op_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode from the accepted key or handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY,
      S_ENTRY: begin
        if (key_acc) begin
          unique case (1'b1)
            is_digit: begin
              if (!lead_zero) begin
                state_d = S_ENTRY;
              end
            end
            is_clr: begin
              state_d = S_EMPTY;
            end
            is_bs: begin
              if (digit_count == 3'd1) begin
                state_d = S_EMPTY;
              end
            end
            is_ent: begin
              state_d = S_HOLD;
            end
            default: begin
            end
          endcase
        end
      end
      S_HOLD: begin
        if (hs) begin
          state_d = S_EMPTY;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    opd_d = operand_bcd;
    cnt_d = digit_count;
    ovf_d = overflow;
    vld_d = op_valid;
`ifdef BCD_ENTRY_SIGN_EN
    sgn_d = sign_neg;
`endif
    unique case (state_q)
      S_EMPTY,
      S_ENTRY: begin
        if (key_acc) begin
          unique case (1'b1)
            is_digit: begin
              if (full) begin
                ovf_d = 1'b1;
              end else if (!lead_zero) begin
                opd_d = {operand_bcd[11:0], key_code};
                cnt_d = digit_count + 3'd1;
              end
            end
            is_clr: begin
              opd_d = 16'h0000;
              cnt_d = 3'd0;
              ovf_d = 1'b0;
`ifdef BCD_ENTRY_SIGN_EN
              sgn_d = 1'b0;
`endif
            end
            is_bs: begin
              if (digit_count != 3'd0) begin
                opd_d = {4'h0, operand_bcd[15:4]};
                cnt_d = digit_count - 3'd1;
              end
            end
            is_ent: begin
              vld_d = 1'b1;
            end
`ifdef BCD_ENTRY_SIGN_EN
            is_sign: begin
              sgn_d = ~sign_neg;
            end
`endif
            default: begin
            end
          endcase
        end
      end
      S_HOLD: begin
        if (hs) begin
          opd_d = 16'h0000;
          cnt_d = 3'd0;
          ovf_d = 1'b0;
          vld_d = 1'b0;
`ifdef BCD_ENTRY_SIGN_EN
          sgn_d = 1'b0;
`endif
        end
      end
      default: begin
        opd_d = 16'h0000;
        cnt_d = 3'd0;
        ovf_d = 1'b0;
        vld_d = 1'b0;
`ifdef BCD_ENTRY_SIGN_EN
        sgn_d = 1'b0;
`endif
      end
    endcase
    rdy_d = state_d != S_HOLD;
  end

  // Output registers; key_ready resets high so keys are taken right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_bcd <= 16'h0000;
      digit_count <= 3'd0;
      overflow    <= 1'b0;
      op_valid    <= 1'b0;
      key_ready   <= 1'b1;
    end else begin
      operand_bcd <= opd_d;
      digit_count <= cnt_d;
      overflow    <= ovf_d;
      op_valid    <= vld_d;
      key_ready   <= rdy_d;
    end
  end

`ifdef BCD_ENTRY_SIGN_EN
  // Sign flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_neg <= 1'b0;
    end else begin
      sign_neg <= sgn_d;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Scoreboard bench for bcd_digit_entry.
// Directed key sequences push expected register images; a monitor pops on each DUT event.
module tb_bcd_digit_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        op_ready = 1'b0;
  logic        key_ready;
  logic [15:0] operand_bcd;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        op_valid;
`ifdef BCD_ENTRY_SIGN_EN
  logic        sign_neg;
`endif

  bcd_digit_entry #(.MAX_DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .operand_bcd (operand_bcd),
    .digit_count (digit_count),
    .overflow    (overflow),
`ifdef BCD_ENTRY_SIGN_EN
    .sign_neg    (sign_neg),
`endif
    .op_valid    (op_valid),
    .op_ready    (op_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] opd;
    logic [2:0]  cnt;
    logic        ovf;
    logic        vld;
    logic        rdy;
  } key_exp_t;

  typedef struct packed {
    logic [15:0] opd;
    logic [2:0]  cnt;
  } op_exp_t;

  key_exp_t key_q[$];
  op_exp_t  op_q[$];
  key_exp_t ke;
  op_exp_t  oe;
  int checks = 0;
  int errors = 0;
  logic pend_key = 1'b0;
  logic pend_hs = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare one cycle after each accepted key and at each handshake.
  always @(negedge clk) begin
    if (pend_key) begin
      if (key_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL key_unexpected: got accept want none");
      end else begin
        ke = key_q.pop_front();
        chk("key_operand", 32'(operand_bcd), 32'(ke.opd));
        chk("key_count", 32'(digit_count), 32'(ke.cnt));
        chk("key_overflow", 32'(overflow), 32'(ke.ovf));
        chk("key_op_valid", 32'(op_valid), 32'(ke.vld));
        chk("key_ready", 32'(key_ready), 32'(ke.rdy));
      end
    end
    if (pend_hs) begin
      chk("hs_clr_operand", 32'(operand_bcd), 32'h0);
      chk("hs_clr_count", 32'(digit_count), 32'h0);
      chk("hs_clr_overflow", 32'(overflow), 32'h0);
      chk("hs_clr_op_valid", 32'(op_valid), 32'h0);
      chk("hs_clr_key_ready", 32'(key_ready), 32'h1);
    end
    if (op_valid && op_ready && rst_n) begin
      if (op_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_unexpected: got handshake want none");
      end else begin
        oe = op_q.pop_front();
        chk("op_operand", 32'(operand_bcd), 32'(oe.opd));
        chk("op_count", 32'(digit_count), 32'(oe.cnt));
      end
      pend_hs <= 1'b1;
    end else begin
      pend_hs <= 1'b0;
    end
    pend_key <= key_valid && key_ready && rst_n;
  end

  task automatic press(input logic [3:0]  code,
                       input logic [15:0] opd,
                       input logic [2:0]  cnt,
                       input logic        ovf);
    key_exp_t e;
    e = '{opd: opd, cnt: cnt, ovf: ovf, vld: 1'b0, rdy: 1'b1};
    key_q.push_back(e);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic press_enter(input logic [15:0] opd,
                             input logic [2:0]  cnt,
                             input logic        ovf);
    key_exp_t e;
    op_exp_t  o;
    e = '{opd: opd, cnt: cnt, ovf: ovf, vld: 1'b1, rdy: 1'b0};
    o = '{opd: opd, cnt: cnt};
    key_q.push_back(e);
    op_q.push_back(o);
    key_valid = 1'b1;
    key_code  = 4'hC;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && op_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (op_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout: got %0d pending want 0", op_q.size());
      op_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_operand", 32'(operand_bcd), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_key_ready", 32'(key_ready), 32'h1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    op_ready = 1'b1;
    press(4'h1, 16'h0001, 3'd1, 1'b0);
    press(4'h2, 16'h0012, 3'd2, 1'b0);
    press(4'h3, 16'h0123, 3'd3, 1'b0);
    press_enter(16'h0123, 3'd3, 1'b0);
    drain();
    op_ready = 1'b0;

    press(4'h0, 16'h0000, 3'd0, 1'b0);
    press(4'h0, 16'h0000, 3'd0, 1'b0);
    press(4'h7, 16'h0007, 3'd1, 1'b0);
    press(4'hA, 16'h0000, 3'd0, 1'b0);

    press(4'h9, 16'h0009, 3'd1, 1'b0);
    press(4'h8, 16'h0098, 3'd2, 1'b0);
    press(4'h7, 16'h0987, 3'd3, 1'b0);
    press(4'h6, 16'h9876, 3'd4, 1'b0);
    press(4'h5, 16'h9876, 3'd4, 1'b1);
    press(4'hB, 16'h0987, 3'd3, 1'b1);
    press(4'hA, 16'h0000, 3'd0, 1'b0);

    press(4'h4, 16'h0004, 3'd1, 1'b0);
    press(4'h5, 16'h0045, 3'd2, 1'b0);
    press(4'hF, 16'h0045, 3'd2, 1'b0);
    press(4'hB, 16'h0004, 3'd1, 1'b0);
    press(4'hB, 16'h0000, 3'd0, 1'b0);
    press(4'hB, 16'h0000, 3'd0, 1'b0);
    press(4'hE, 16'h0000, 3'd0, 1'b0);

    press(4'h5, 16'h0005, 3'd1, 1'b0);
    press(4'h6, 16'h0056, 3'd2, 1'b0);
    press(4'hB, 16'h0005, 3'd1, 1'b0);
    press(4'h8, 16'h0058, 3'd2, 1'b0);
    press(4'hA, 16'h0000, 3'd0, 1'b0);

    press(4'h3, 16'h0003, 3'd1, 1'b0);
    press_enter(16'h0003, 3'd1, 1'b0);
    key_valid = 1'b1;
    key_code  = 4'h3;
    repeat (5) begin
      @(negedge clk);
      chk("hold_key_ready", 32'(key_ready), 32'h0);
      chk("hold_operand", 32'(operand_bcd), 32'h0003);
      chk("hold_op_valid", 32'(op_valid), 32'h1);
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    op_ready  = 1'b1;
    drain();

    press_enter(16'h0000, 3'd0, 1'b0);
    drain();
    op_ready = 1'b0;

    press(4'h4, 16'h0004, 3'd1, 1'b0);
    press(4'h2, 16'h0042, 3'd2, 1'b0);
    press_enter(16'h0042, 3'd2, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_operand", 32'(operand_bcd), 32'h0);
    chk("async_count", 32'(digit_count), 32'h0);
    chk("async_overflow", 32'(overflow), 32'h0);
    chk("async_op_valid", 32'(op_valid), 32'h0);
    chk("async_key_ready", 32'(key_ready), 32'h1);
    op_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    press(4'h8, 16'h0008, 3'd1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("key_q_drained", 32'(key_q.size()), 32'h0);
    chk("op_q_drained", 32'(op_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_digit_entry.md
BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
  MAX_DIGITS  4  number of BCD digits held in the operand register (fixed at 4 for this release).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on its rising edge.
  rst_n  input  1  reset, asynchronous and active-low.
  key_valid  input  1  key_code is presented this cycle.
  key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD-0xF reserved.
  key_ready  output  1  block can accept a key this cycle.
  operand_bcd  output  16  packed BCD operand; [3:0] is the least-significant digit, feeds the BCD adder digit inputs.
  digit_count  output  3  number of significant digits entered, 0-4.
  overflow  output  1  sticky; a digit was dropped because the register was full.
  op_valid  output  1  operand is complete and offered downstream.
  op_ready  input  1  downstream accepts the operand.

Function
REQ-003 A key SHALL be accepted only on a cycle with key_valid=1 and key_ready=1; otherwise it has no effect.
REQ-004 The FSM SHALL have three states: EMPTY (count 0), ENTRY (count 1-4) and HOLD (operand offered).
REQ-005 key_ready SHALL be 1 in EMPTY and ENTRY, and 0 in HOLD.
REQ-006 Accepted digit d with count<4: operand_bcd <= {operand_bcd[11:0], d}, count+1, next state ENTRY.
REQ-007 Accepted digit 0 with count=0 (leading zero): no change, state stays EMPTY.
REQ-008 Accepted digit with count=4: operand unchanged; overflow <= 1.
REQ-009 Backspace: operand_bcd <= {4'h0, operand_bcd[15:4]} and count-1; moves to EMPTY when count reaches 0; no-op at count 0; overflow is unchanged.
REQ-010 Clear: operand 0, count 0, overflow 0, state EMPTY.
REQ-011 Enter (from EMPTY or ENTRY): state HOLD with op_valid=1 from the next cycle; operand and count frozen; enter at count 0 offers 0x0000.
REQ-012 op_valid SHALL stay 1, with operand_bcd stable, until a cycle with op_valid=1 and op_ready=1.
REQ-013 On that handshake cycle: next cycle op_valid=0, operand 0, count 0, overflow 0, state EMPTY.
REQ-014 op_ready while op_valid=0 SHALL be ignored.
REQ-015 Reserved codes 0xD-0xF SHALL be accepted and produce no state change, except as modified by REQ-022.
REQ-016 All outputs SHALL be registered; the effect of an accepted key appears exactly one cycle after acceptance.
REQ-017 operand_bcd SHALL contain only digits 0-9 at all times; key_code values are never written unchecked.

Reset
REQ-018 Asserting rst_n low SHALL immediately and asynchronously force: operand_bcd=0, digit_count=0, overflow=0, op_valid=0, state EMPTY.
REQ-019 key_ready SHALL read 1 during and after reset.
REQ-020 Reset during HOLD SHALL abandon the offered operand with no handshake.
REQ-021 Release of rst_n SHALL be treated as synchronous to clk; the first key can be accepted on the first rising edge after release.

Configuration
REQ-022 With macro BCD_ENTRY_SIGN_EN defined: an extra output port sign_neg (1 bit, reset 0) is present; key 0xD toggles sign_neg in EMPTY/ENTRY; sign_neg is frozen in HOLD; it is cleared by clear, by the handshake and by reset.
REQ-023 Without BCD_ENTRY_SIGN_EN: sign_neg is absent and 0xD is treated as a reserved code.

Verification
REQ-024 Keys 1,2,3,C; op_ready=1 -> operand_bcd=0x0123, count 3, op_valid one cycle after enter, then all cleared one cycle after the handshake.
REQ-025 Keys 0,0,7 -> operand 0x0007, count 1.
REQ-026 Keys 9,8,7,6,5 -> operand 0x9876, count 4, overflow=1; then A -> all zero, overflow=0.
REQ-027 Keys 4,5,B,B,B -> 0x0045, then 0x0004, then 0x0000 in EMPTY, third B is a no-op.
REQ-028 Enter with op_ready=0 for 5 cycles while key_valid=1 with digit 3 -> key_ready=0, operand stable, digit ignored; op_ready=1 -> back to EMPTY.
REQ-029 rst_n pulsed low mid-HOLD between clock edges -> outputs zero immediately, without waiting for a clock edge.
